// File: rtl/task_dispatch.sv
// task_dispatch: queues up to DEPTH requests per channel and hands them one at a
// time to a single consumer (level req / pulse ack), serving channels round-robin.
// Latency: dispatch one edge after a count becomes non-zero; optional watchdog abort.
module task_dispatch #(
  parameter int NCH     = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 0,
  parameter int TW      = 16,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req_i,
  output logic [NCH-1:0] busy_o,
  output logic [NCH-1:0] ack_o,
  output logic [NCH-1:0] drop_o,
  output logic           task_req_o,
  output logic [CW-1:0]  task_ch_o,
  input  logic           task_ack_i,
  output logic           timeout_o,
  output logic [NCH-1:0] pending_o
);

  localparam int KW = $clog2(DEPTH + 1);
  localparam logic [KW-1:0] FULL = KW'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [KW-1:0]   cnt [NCH];
  logic [CW-1:0]   last;
  logic [TW-1:0]   wd;
  logic            wd_expire;
  logic            finish;
  logic [NCH-1:0]  accept;
  logic [NCH-1:0]  retire;
  logic            pick_vld;
  logic [CW-1:0]   pick_ch;

  // Watchdog comparison only exists when a timeout length is configured.
  generate
    if (TIMEOUT > 0) begin : g_wd
      assign wd_expire = (wd == TW'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  // A task ends on ack, or on watchdog expiry when no ack arrives that cycle.
  assign finish = (state == WAIT) && (task_ack_i || wd_expire);

  // Channel status flags and per-channel accept/retire decisions from the pre-edge counts.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      busy_o[c]    = (cnt[c] == FULL);
      pending_o[c] = (cnt[c] != '0);
      accept[c]    = req_i[c] && (cnt[c] != FULL);
      retire[c]    = finish && (task_ch_o == CW'(c));
    end
  end

  // Round-robin search: first channel with work, starting just after the last served one.
  always_comb begin
    int idx;
    logic [CW-1:0] sel;
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last) + k) % NCH;
      sel = CW'(idx);
      if (!pick_vld && (cnt[sel] != '0)) begin
        pick_vld = 1'b1;
        pick_ch  = sel;
      end
    end
  end

  // Outstanding-task counters; a simultaneous accept and retire leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (accept[c] && !retire[c]) begin
          cnt[c] <= cnt[c] + KW'(1);
        end else if (!accept[c] && retire[c]) begin
          cnt[c] <= cnt[c] - KW'(1);
        end
      end
    end
  end

  // Drop pulse for any request that arrived while its channel was already full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_o <= '0;
    end else begin
      drop_o <= req_i & busy_o;
    end
  end

  // Dispatch FSM: present one task, wait for ack or watchdog, then return to IDLE for a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      task_req_o <= 1'b0;
      task_ch_o  <= '0;
      ack_o      <= '0;
      timeout_o  <= 1'b0;
      last       <= CW'(NCH - 1);
      wd         <= '0;
    end else begin
      ack_o     <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            task_ch_o  <= pick_ch;
            task_req_o <= 1'b1;
            wd         <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (task_ack_i) begin
            task_req_o        <= 1'b0;
            ack_o[task_ch_o]  <= 1'b1;
            last              <= task_ch_o;
            state             <= IDLE;
          end else if (wd_expire) begin
            task_req_o <= 1'b0;
            timeout_o  <= 1'b1;
            last       <= task_ch_o;
            state      <= IDLE;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_dispatch.sv
// Bench for task_dispatch: directed vector table, hand-written watchdog/reset
// sequences, and randomized traffic against a behavioural model.
module tb_task_dispatch;

  localparam int NCH   = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT without watchdog
  logic [3:0] req0, busy0, ack0, drop0, pend0;
  logic       ack_in0, treq0, tmo0;
  logic [1:0] tch0;
  // DUT with an 8-cycle watchdog
  logic [3:0] req1, busy1, ack1, drop1, pend1;
  logic       ack_in1, treq1, tmo1;
  logic [1:0] tch1;

  task_dispatch #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(0), .TW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .busy_o(busy0), .ack_o(ack0),
    .drop_o(drop0), .task_req_o(treq0), .task_ch_o(tch0), .task_ack_i(ack_in0),
    .timeout_o(tmo0), .pending_o(pend0));

  task_dispatch #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(8), .TW(16)) dutw (
    .clk(clk), .rst_n(rst_n), .req_i(req1), .busy_o(busy1), .ack_o(ack1),
    .drop_o(drop1), .task_req_o(treq1), .task_ch_o(tch1), .task_ack_i(ack_in1),
    .timeout_o(tmo1), .pending_o(pend1));

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [3:0] req;
    logic       ack;
    logic       treq;
    logic [1:0] ch;
    logic [3:0] ack_e;
    logic [3:0] drop_e;
    logic [3:0] pend_e;
    logic [3:0] busy_e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] rq, input logic ak, input logic tr, input logic [1:0] ch,
                     input logic [3:0] ae, input logic [3:0] de, input logic [3:0] pe,
                     input logic [3:0] be);
    vec_t v;
    v.req = rq; v.ack = ak; v.treq = tr; v.ch = ch;
    v.ack_e = ae; v.drop_e = de; v.pend_e = pe; v.busy_e = be;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0][3:0] cnt;
    logic            act;
    logic [1:0]      ch;
    logic [1:0]      last;
    logic [15:0]     age;
    logic [3:0]      ack;
    logic [3:0]      drop;
    logic            tmo;
  } model_t;

  function automatic model_t mreset();
    model_t m;
    m = '0;
    m.last = 2'(NCH - 1);
    return m;
  endfunction

  function automatic model_t mstep(input model_t m, input logic [3:0] req, input logic ack,
                                   input int to);
    model_t n;
    logic [3:0] fin;
    bit found;
    int c;
    n = m;
    n.ack = '0; n.drop = '0; n.tmo = 1'b0; fin = '0;
    for (int i = 0; i < NCH; i++)
      if (req[i] && int'(m.cnt[i]) == DEPTH) n.drop[i] = 1'b1;
    if (m.act) begin
      if (ack) begin
        n.ack[m.ch] = 1'b1; fin[m.ch] = 1'b1;
      end else if (to > 0 && int'(m.age) == to - 1) begin
        n.tmo = 1'b1; fin[m.ch] = 1'b1;
      end else begin
        n.age = m.age + 16'd1;
      end
      if (fin != 0) begin
        n.act = 1'b0; n.last = m.ch;
      end
    end else begin
      found = 0;
      for (int k = 1; k <= NCH; k++) begin
        c = (int'(m.last) + k) % NCH;
        if (!found && m.cnt[c] != 0) begin
          found = 1; n.act = 1'b1; n.ch = 2'(c); n.age = '0;
        end
      end
    end
    for (int i = 0; i < NCH; i++)
      n.cnt[i] = 4'(int'(m.cnt[i]) + ((req[i] && int'(m.cnt[i]) < DEPTH) ? 1 : 0)
                    - (fin[i] ? 1 : 0));
    return n;
  endfunction

  task automatic cmp(input string tag, input model_t m, input logic tr, input logic [1:0] ch,
                     input logic [3:0] ak, input logic [3:0] dr, input logic tm,
                     input logic [3:0] pe, input logic [3:0] bu);
    logic [3:0] pe_e, bu_e;
    for (int i = 0; i < NCH; i++) begin
      pe_e[i] = (m.cnt[i] != 0);
      bu_e[i] = (int'(m.cnt[i]) == DEPTH);
    end
    check({tag, " task_req"}, 32'(tr), 32'(m.act));
    if (m.act) check({tag, " task_ch"}, 32'(ch), 32'(m.ch));
    check({tag, " ack"}, 32'(ak), 32'(m.ack));
    check({tag, " drop"}, 32'(dr), 32'(m.drop));
    check({tag, " timeout"}, 32'(tm), 32'(m.tmo));
    check({tag, " pending"}, 32'(pe), 32'(pe_e));
    check({tag, " busy"}, 32'(bu), 32'(bu_e));
  endtask

  // Hard stop in case something stalls beyond every bounded loop.
  initial begin
    #500000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_t m0, mw;
    int n, hold, ack_seen;

    rst_n = 1'b0;
    req0 = '0; ack_in0 = 1'b0; req1 = '0; ack_in1 = 1'b0;
    step();
    // reset state of both instances
    check("rst treq0", 32'(treq0), 0);
    check("rst ch0", 32'(tch0), 0);
    check("rst outs0", {busy0, ack0, drop0, pend0, 3'b0, tmo0}, 0);
    check("rst treq1", 32'(treq1), 0);
    check("rst outs1", {busy1, ack1, drop1, pend1, 3'b0, tmo1}, 0);
    step();
    rst_n = 1'b1;

    // round-robin, ack in idle ignored
    add(4'b1111,0, 0,0, 4'b0000,4'b0000,4'b1111,4'b0000);
    add(4'b0000,0, 1,0, 4'b0000,4'b0000,4'b1111,4'b0000);
    add(4'b0000,1, 0,0, 4'b0001,4'b0000,4'b1110,4'b0000);
    add(4'b0000,0, 1,1, 4'b0000,4'b0000,4'b1110,4'b0000);
    add(4'b0000,1, 0,0, 4'b0010,4'b0000,4'b1100,4'b0000);
    add(4'b0000,0, 1,2, 4'b0000,4'b0000,4'b1100,4'b0000);
    add(4'b0000,1, 0,0, 4'b0100,4'b0000,4'b1000,4'b0000);
    add(4'b0000,0, 1,3, 4'b0000,4'b0000,4'b1000,4'b0000);
    add(4'b0000,1, 0,0, 4'b1000,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1, 0,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    // single request, ack after 3 cycles
    add(4'b0001,0, 0,0, 4'b0000,4'b0000,4'b0001,4'b0000);
    add(4'b0000,0, 1,0, 4'b0000,4'b0000,4'b0001,4'b0000);
    add(4'b0000,0, 1,0, 4'b0000,4'b0000,4'b0001,4'b0000);
    add(4'b0000,0, 1,0, 4'b0000,4'b0000,4'b0001,4'b0000);
    add(4'b0000,1, 0,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,0, 0,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    // depth and drop on channel 2
    add(4'b0100,0, 0,0, 4'b0000,4'b0000,4'b0100,4'b0000);
    add(4'b0100,0, 1,2, 4'b0000,4'b0000,4'b0100,4'b0100);
    add(4'b0100,0, 1,2, 4'b0000,4'b0100,4'b0100,4'b0100);
    add(4'b0100,0, 1,2, 4'b0000,4'b0100,4'b0100,4'b0100);
    add(4'b0000,0, 1,2, 4'b0000,4'b0000,4'b0100,4'b0100);
    add(4'b0000,1, 0,0, 4'b0100,4'b0000,4'b0100,4'b0000);
    add(4'b0000,0, 1,2, 4'b0000,4'b0000,4'b0100,4'b0000);
    add(4'b0000,1, 0,0, 4'b0100,4'b0000,4'b0000,4'b0000);
    add(4'b0000,0, 0,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    // simultaneous accept and retire on channel 1
    add(4'b0010,0, 0,0, 4'b0000,4'b0000,4'b0010,4'b0000);
    add(4'b0000,0, 1,1, 4'b0000,4'b0000,4'b0010,4'b0000);
    add(4'b0010,1, 0,0, 4'b0010,4'b0000,4'b0010,4'b0000);
    add(4'b0000,0, 1,1, 4'b0000,4'b0000,4'b0010,4'b0000);
    add(4'b0000,1, 0,0, 4'b0010,4'b0000,4'b0000,4'b0000);
    add(4'b0000,0, 0,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    // full channel: retire at the same edge does not rescue the request
    add(4'b0010,0, 0,0, 4'b0000,4'b0000,4'b0010,4'b0000);
    add(4'b0010,0, 1,1, 4'b0000,4'b0000,4'b0010,4'b0010);
    add(4'b0010,1, 0,0, 4'b0010,4'b0010,4'b0010,4'b0000);
    add(4'b0000,0, 1,1, 4'b0000,4'b0000,4'b0010,4'b0000);
    add(4'b0000,1, 0,0, 4'b0010,4'b0000,4'b0000,4'b0000);
    add(4'b0000,0, 0,0, 4'b0000,4'b0000,4'b0000,4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      req0 = tbl[i].req;
      ack_in0 = tbl[i].ack;
      step();
      check({t, " task_req"}, 32'(treq0), 32'(tbl[i].treq));
      if (tbl[i].treq) check({t, " task_ch"}, 32'(tch0), 32'(tbl[i].ch));
      check({t, " ack"}, 32'(ack0), 32'(tbl[i].ack_e));
      check({t, " drop"}, 32'(drop0), 32'(tbl[i].drop_e));
      check({t, " pending"}, 32'(pend0), 32'(tbl[i].pend_e));
      check({t, " busy"}, 32'(busy0), 32'(tbl[i].busy_e));
      check({t, " timeout"}, 32'(tmo0), 0);
    end
    req0 = '0; ack_in0 = 1'b0;

    // watchdog: two tasks, never acknowledged
    req1 = 4'b0011;
    step();
    req1 = '0;
    check("wd pend", 32'(pend1), 32'b0011);
    step();
    check("wd rise0", 32'(treq1), 1);
    check("wd ch0", 32'(tch1), 0);
    for (int t = 0; t < 2; t++) begin
      n = 0; ack_seen = 0;
      for (int k = 1; k <= 20; k++) begin
        step();
        if (ack1 != 0) ack_seen = 1;
        if (tmo1) begin n = k; break; end
      end
      check($sformatf("wd cycles%0d", t), 32'(n), 8);
      check($sformatf("wd noack%0d", t), 32'(ack_seen), 0);
      check($sformatf("wd treq_low%0d", t), 32'(treq1), 0);
      check($sformatf("wd pend%0d", t), 32'(pend1), (t == 0) ? 32'b0010 : 32'b0000);
      if (t == 0) begin
        step();
        check("wd rise1", 32'(treq1), 1);
        check("wd ch1", 32'(tch1), 1);
      end
    end

    // no watchdog: the task stays presented
    req0 = 4'b0001;
    step();
    req0 = '0;
    step();
    hold = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (treq0 && !tmo0 && ack0 == 0) hold++;
    end
    check("nowd hold", 32'(hold), 1000);
    ack_in0 = 1'b1;
    step();
    check("nowd ack", 32'(ack0), 32'b0001);
    ack_in0 = 1'b0;
    step();

    // randomized traffic against the model on both instances
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m0 = mreset();
    mw = mreset();
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < NCH; b++) begin
        req0[b] = ($urandom_range(0, 3) == 0);
        req1[b] = ($urandom_range(0, 3) == 0);
      end
      ack_in0 = ($urandom_range(0, 2) == 0);
      ack_in1 = ($urandom_range(0, 7) == 0);
      m0 = mstep(m0, req0, ack_in0, 0);
      mw = mstep(mw, req1, ack_in1, 8);
      step();
      cmp("rnd0", m0, treq0, tch0, ack0, drop0, tmo0, pend0, busy0);
      cmp("rndw", mw, treq1, tch1, ack1, drop1, tmo1, pend1, busy1);
    end
    req1 = '0; ack_in1 = 1'b0;

    // reset in the middle of a task with counts 2,1,0,1
    req0 = '0; ack_in0 = 1'b1;
    for (int k = 0; k < 20; k++) step();
    ack_in0 = 1'b0;
    req0 = 4'b1011;
    step();
    req0 = 4'b0001;
    step();
    req0 = '0;
    check("mid pend", 32'(pend0), 32'b1011);
    check("mid busy", 32'(busy0), 32'b0001);
    check("mid treq", 32'(treq0), 1);
    ack_in0 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst treq", 32'(treq0), 0);
    check("mid rst ch", 32'(tch0), 0);
    check("mid rst outs", {busy0, ack0, drop0, pend0, 3'b0, tmo0}, 0);
    step();
    check("mid rst noack", 32'(ack0), 0);
    ack_in0 = 1'b0;
    rst_n = 1'b1;
    step();
    check("post rst ack", 32'(ack0), 0);
    check("post rst pend", 32'(pend0), 0);
    req0 = 4'b1001;
    step();
    req0 = '0;
    step();
    check("post rst treq", 32'(treq0), 1);
    check("post rst ch", 32'(tch0), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
